// File: rtl/cp0_exc_ctrl_if.sv
// Commit / CP0 / fetch-redirect bundle for the exception controller.
// master: write-back stage + CP0 + fetch side; slave: cp0_exc_ctrl.
interface cp0_exc_ctrl_if;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic        ws_bd;
    logic [6:0]  ws_exc_flags;   // {ades, adel_d, bp, sys, ov, ri, adel_f}
    logic [31:0] ws_data_vaddr;
    logic        ws_eret_in;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        wb_ex;
    logic        wb_bd;
    logic        ws_eret;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output ws_valid, ws_pc, ws_bd, ws_exc_flags, ws_data_vaddr, ws_eret_in,
               cp0_status, cp0_cause, cp0_epc, redirect_ready,
        input  wb_ex, wb_bd, ws_eret, wb_excode, wb_pc, wb_badvaddr, flush,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  ws_valid, ws_pc, ws_bd, ws_exc_flags, ws_data_vaddr, ws_eret_in,
               cp0_status, cp0_cause, cp0_epc, redirect_ready,
        output wb_ex, wb_bd, ws_eret, wb_excode, wb_pc, wb_badvaddr, flush,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception / ERET commit controller.
// Picks the highest-priority exception of the committing instruction,
// strobes the record to CP0 and flushes in the commit cycle, then holds a
// fetch redirect (exception vector or EPC) until fetch accepts it.
// Interrupt detection is built only when CP0_EXC_INT_EN is defined.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_ctrl_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] redirect_pc_q;
    logic        int_q;
    logic        exc_any;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        commit, take_exc, take_eret;

    // Status/cause bits outside the interrupt fields are not needed here.
    logic unused_cp0;
    assign unused_cp0 = ^{bus.cp0_status, bus.cp0_cause};

`ifdef CP0_EXC_INT_EN
    // Pending-interrupt flag, sampled every cycle whatever the FSM state.
    always_ff @(posedge clk) begin
        if (reset) int_q <= 1'b0;
        else       int_q <= |(bus.cp0_cause[15:8] & bus.cp0_status[15:8])
                            & bus.cp0_status[0] & ~bus.cp0_status[1];
    end
`else
    assign int_q = 1'b0;
`endif

    // Priority pick of excode and bad address for the committing instruction.
    always_comb begin
        exc_any  = int_q | (|bus.ws_exc_flags);
        excode   = 5'h00;
        badvaddr = 32'h0;
        if (int_q)                    excode = 5'h00;
        else if (bus.ws_exc_flags[0]) begin excode = 5'h04; badvaddr = bus.ws_pc; end
        else if (bus.ws_exc_flags[1]) excode = 5'h0A;
        else if (bus.ws_exc_flags[2]) excode = 5'h0C;
        else if (bus.ws_exc_flags[3]) excode = 5'h08;
        else if (bus.ws_exc_flags[4]) excode = 5'h09;
        else if (bus.ws_exc_flags[5]) begin excode = 5'h04; badvaddr = bus.ws_data_vaddr; end
        else if (bus.ws_exc_flags[6]) begin excode = 5'h05; badvaddr = bus.ws_data_vaddr; end
    end

    // Commits only count in IDLE; reset masks every strobe.
    assign commit    = (state_q == IDLE) & bus.ws_valid & ~reset;
    assign take_exc  = commit & exc_any;
    assign take_eret = commit & bus.ws_eret_in & ~exc_any;

    // State and redirect target; the target is frozen for the whole handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (take_exc)       redirect_pc_q <= EXC_VECTOR;
            else if (take_eret) redirect_pc_q <= bus.cp0_epc;
        end
    end

    // Next state: exception/ERET commit starts a redirect, ready ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (take_exc | take_eret) state_d = REDIRECT;
            REDIRECT: if (bus.redirect_ready)   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs: commit strobes are combinational, redirect comes from state.
    always_comb begin
        bus.wb_ex          = take_exc;
        bus.ws_eret        = take_eret;
        bus.flush          = take_exc | take_eret;
        bus.wb_bd          = bus.ws_bd;
        bus.wb_pc          = bus.ws_pc;
        bus.wb_excode      = excode;
        bus.wb_badvaddr    = badvaddr;
        bus.redirect_valid = (state_q == REDIRECT);
        bus.redirect_pc    = redirect_pc_q;
    end
endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, exception entry address (Status.BEV=1).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ws_valid  input  1  write-back stage holds an instruction committing this cycle.
REQ-005 SHALL have port ws_pc  input  32  PC of the committing instruction.
REQ-006 SHALL have port ws_bd  input  1  committing instruction is in a branch delay slot.
REQ-007 SHALL have port ws_exc_flags  input  7  raw exception flags {ades, adel_d, bp, sys, ov, ri, adel_f}, bit0 = adel_f.
REQ-008 SHALL have port ws_data_vaddr  input  32  data address of a faulting load or store.
REQ-009 SHALL have port ws_eret_in  input  1  committing instruction is ERET.
REQ-010 SHALL have ports cp0_status, cp0_cause, cp0_epc  input  32 each  current CP0 register values.
REQ-011 SHALL have ports wb_ex, wb_bd, ws_eret  output  1 each  commit strobes to CP0.
REQ-012 SHALL have ports wb_excode  output  5, wb_pc  output  32, wb_badvaddr  output  32  exception record to CP0.
REQ-013 SHALL have port flush  output  1  one-cycle pipeline flush pulse.
REQ-014 SHALL have ports redirect_valid  output  1, redirect_pc  output  32, redirect_ready  input  1  fetch redirect handshake.

Function
REQ-015 SHALL register int_q each cycle: int_q <= |(cause[15:8] & status[15:8]) & status[0] & ~status[1].
REQ-016 SHALL implement states IDLE and REDIRECT; commit is evaluated only in IDLE with ws_valid=1.
REQ-017 SHALL select the exception by priority: INT(0x00) > adel_f(0x04) > ri(0x0A) > ov(0x0C) > sys(0x08) > bp(0x09) > adel_d(0x04) > ades(0x05).
REQ-018 SHALL, on a commit with any exception, drive wb_ex=1, wb_excode as selected, wb_bd=ws_bd, wb_pc=ws_pc, flush=1, combinationally in the commit cycle.
REQ-019 SHALL drive wb_badvaddr=ws_pc for adel_f, ws_data_vaddr for adel_d/ades, 0 otherwise.
REQ-020 SHALL, on a commit with ws_eret_in=1 and no exception, drive ws_eret=1 and flush=1; the exception wins if both apply, and ws_eret stays 0.
REQ-021 SHALL, in the cycle after an exception commit, enter REDIRECT with redirect_pc=EXC_VECTOR; after an ERET commit, redirect_pc is the cp0_epc captured in the commit cycle.
REQ-022 SHALL hold redirect_valid=1 and a stable redirect_pc in REDIRECT until redirect_ready=1, then return to IDLE the next cycle.
REQ-023 SHALL ignore ws_valid in REDIRECT; wb_ex, ws_eret, and flush stay 0 even if redirect_ready and ws_valid coincide.
REQ-024 SHALL leave a commit without an exception or ERET invisible: all strobes 0, state unchanged.
REQ-025 SHALL keep int_q sampling independent of state.

Reset
REQ-026 SHALL, while reset=1, set the state to IDLE, int_q=0, redirect_valid=0, redirect_pc=0, and force wb_ex, ws_eret, and flush to 0 regardless of ws_valid.
REQ-027 SHALL abort REDIRECT on reset mid-handshake, with no redirect issued after reset deasserts.

Configuration
REQ-028 SHALL compile interrupt detection only when macro CP0_EXC_INT_EN is defined.
REQ-029 SHALL, without CP0_EXC_INT_EN, tie int_q to 0 so excode 0x00 is never produced; all other behaviour is identical.

Verification
REQ-030 SHALL cover: ws_valid=1, ws_pc=0xBFC00100, ws_exc_flags=7'b0000100 (ov) -> same cycle wb_ex=1, excode=0x0C, flush=1; next cycle redirect_valid=1, redirect_pc=0xBFC00380.
REQ-031 SHALL cover: ws_exc_flags=7'b0100010 (adel_d+ri), ws_data_vaddr=0x80000003 -> excode=0x0A, wb_badvaddr=0.
REQ-032 SHALL cover: ws_eret_in=1, cp0_epc=0xBFC00200, no flags -> ws_eret=1, flush=1; then redirect_pc=0xBFC00200; hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable; ready=1 -> IDLE.
REQ-033 SHALL cover: status=0x0000FF01, cause IP7=1, one cycle later ws_valid=1 with sys flag -> excode=0x00 (0x08 when CP0_EXC_INT_EN is undefined).
REQ-034 SHALL cover: in REDIRECT with ws_valid=1 and exception flags set -> no wb_ex and no flush; reset asserted mid-REDIRECT -> redirect_valid=0 next cycle.
REQ-035 SHALL cover: ws_eret_in=1 with adel_f, ws_pc=0x00000002 -> wb_ex=1, ws_eret=0, wb_badvaddr=0x00000002, excode=0x04.
